// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Brief    : Shared LFSR definitions: checker state, next-state function and
//            the active-low 7-segment hex table.
// Revision : 1.0
// ============================================================================
package lfsr_pkg;

    localparam int c_LFSR_W = 8;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // seg[7:1] = a..g, seg[0] = dp; active-low, dp kept dark. Index 15 first.
    localparam logic [15:0][7:0] c_SEG_TABLE = {
        8'h71, 8'h61, 8'h85, 8'h63,   // F E d C
        8'hC1, 8'h11, 8'h09, 8'h01,   // b A 9 8
        8'h1F, 8'h41, 8'h49, 8'h99,   // 7 6 5 4
        8'h0D, 8'h25, 8'h9F, 8'h03    // 3 2 1 0
    };

    // The all-zero word is a lock-up state for this polynomial; escape to 01.
    function automatic logic [c_LFSR_W-1:0] nxt(input logic [c_LFSR_W-1:0] s);
        if (s == '0) begin
            return 8'h01;
        end
        return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
    endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_checker_seg7_hex.sv
`default_nettype none
// ============================================================================
// Module   : seg7_hex
// Brief    : Combinational 4-bit hex to active-low 7-segment (+dp) decoder.
// Revision : 1.0
// ============================================================================
module seg7_hex
    import lfsr_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [7:0] o_seg
);

    assign o_seg = c_SEG_TABLE[i_hex];

endmodule : seg7_hex
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_checker
// Brief    : Locks onto an 8-bit LFSR state stream and counts mismatches,
//            with lock flag, error pulse, saturating count and hex display.
// Revision : 1.0
// ============================================================================
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [7:0]          data,
    output logic                locked,
    output logic                err,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [7:0]          expected,
    output logic [7:0]          seg
);

    localparam int c_MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int c_MISS_W  = $clog2(LOSS_CNT + 1);

    state_t                 r_state;
    logic                   r_locked;
    logic                   r_err;
    logic [CNT_W-1:0]       r_err_cnt;
    logic [7:0]             r_expected;
    logic [c_MATCH_W-1:0]   r_match_cnt;
    logic [c_MISS_W-1:0]    r_miss_cnt;

    logic [7:0]             w_data_nxt;
    logic [7:0]             w_exp_nxt;
    logic                   w_hit;
    logic [c_MATCH_W-1:0]   w_match_inc;
    logic [c_MISS_W-1:0]    w_miss_inc;

    assign w_data_nxt  = nxt(data);
    assign w_exp_nxt   = nxt(r_expected);
    assign w_hit       = (data == r_expected);
    assign w_match_inc = r_match_cnt + c_MATCH_W'(1);
    assign w_miss_inc  = r_miss_cnt + c_MISS_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SEED;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_expected  <= 8'h00;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_err <= 1'b0;
            if (valid) begin
                case (r_state)
                    ST_SEED: begin
                        r_expected  <= w_data_nxt;
                        r_match_cnt <= '0;
                        r_state     <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        // Hunting: follow the observed data whether it matched or not.
                        r_expected <= w_data_nxt;
                        if (w_hit) begin
                            if (w_match_inc == c_MATCH_W'(LOCK_CNT)) begin
                                r_state     <= ST_LOCKED;
                                r_locked    <= 1'b1;
                                r_miss_cnt  <= '0;
                                r_match_cnt <= '0;
                            end else begin
                                r_match_cnt <= w_match_inc;
                            end
                        end else begin
                            r_match_cnt <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Free-running prediction; bad words never resync the sequence.
                        r_expected <= w_exp_nxt;
                        if (w_hit) begin
                            r_miss_cnt <= '0;
                        end else begin
                            r_err <= 1'b1;
                            if (r_err_cnt != '1) begin
                                r_err_cnt <= r_err_cnt + CNT_W'(1);
                            end
                            if (w_miss_inc == c_MISS_W'(LOSS_CNT)) begin
                                r_state    <= ST_SEED;
                                r_locked   <= 1'b0;
                                r_miss_cnt <= '0;
                            end else begin
                                r_miss_cnt <= w_miss_inc;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_SEED;
                    end
                endcase
            end
        end
    end

    assign locked   = r_locked;
    assign err      = r_err;
    assign err_cnt  = r_err_cnt;
    assign expected = r_expected;

    seg7_hex u_seg7_hex (
        .i_hex (r_err_cnt[3:0]),
        .o_seg (seg)
    );

endmodule : lfsr_checker
`default_nettype wire

// File: doc/lfsr_checker.md
# lfsr_checker

Receiving end of the 8-bit LFSR pattern generator. Samples the generator's 8-bit state word each valid cycle, seeds and locks onto the sequence, then counts mismatches against its own free-running prediction. Drives a lock flag, an error pulse, a saturating error counter and an active-low 7-segment digit for the counter's low nibble, so the board display shows link health.

## Interface
- LOCK_CNT, 4, consecutive matches in SYNC required to enter LOCKED (≥1)
- LOSS_CNT, 3, consecutive mismatches in LOCKED that drop lock (≥1)
- CNT_W, 16, width of err_cnt
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- valid  in  1  data is a sampled LFSR state this cycle
- data  in  8  observed LFSR state word
- locked  out  1  checker tracking the sequence
- err  out  1  one-cycle pulse per mismatch while LOCKED
- err_cnt  out  CNT_W  saturating mismatch count, cleared only by rst
- expected  out  8  predicted next state word
- seg  out  8  active-low 7-seg of err_cnt[3:0]; seg[7:1]=a..g, seg[0]=dp (dp always off, =1)

## Operation
- Next-state function nxt(s) = {s[4]^s[3]^s[2]^s[0], s[7:1]}; nxt(8'h00) = 8'h01 (all-zero escape).
- States: SEED, SYNC, LOCKED. Internal counters: match_cnt, miss_cnt.
- rst (priority over everything): state=SEED, locked=0, err=0, err_cnt=0, expected=8'h00, match_cnt=0, miss_cnt=0, seg=8'h03 (digit 0).
- valid=0: all state held, err=0.
- SEED, valid: expected<=nxt(data), match_cnt=0 -> SYNC.
- SYNC, valid, data==expected: expected<=nxt(data), match_cnt+1; when match count reaches LOCK_CNT -> LOCKED, locked=1, miss_cnt=0.
- SYNC, valid, mismatch: reseed expected<=nxt(data), match_cnt=0, stay SYNC; no error counted.
- LOCKED, valid, match: expected<=nxt(expected), miss_cnt=0.
- LOCKED, valid, mismatch: err=1, err_cnt+1 (saturates at all-ones), expected<=nxt(expected) (no resync), miss_cnt+1; reaching LOSS_CNT -> SEED, locked=0.
- seg is a pure decode of registered err_cnt[3:0] (hex 0–F), so it follows err_cnt in the same cycle.

## Timing
- All outputs registered; response appears the cycle after the valid sample.
- locked rises the cycle after the LOCK_CNT-th consecutive match; falls the cycle after the LOSS_CNT-th consecutive miss.
- err is high for exactly one cycle per mismatched valid sample; back-to-back mismatches give back-to-back pulses.
- A match in LOCKED clears miss_cnt, so only consecutive misses cause loss.
- err_cnt persists across lock loss and relock.

## Structure
- Package lfsr_pkg: state enum, LFSR width constant, nxt() function (shared with the generator), 16-entry active-low seg table.
- Sub-module seg7_hex: 4-bit hex to 8-bit active-low segment decoder. It is combinational and reusable by the generator's display.
- The checker FSM plus counters are in lfsr_checker.

## Test plan
- Lock: rst, then valid data 01,80,40,20,10 -> SEED->SYNC on 01; locked=1 the cycle after 10; expected=8'h88.
- Single error: locked, send 00 instead of 88 -> err one cycle, err_cnt=1, seg=decode(1), expected=8'hC4; send C4 -> no err, still locked.
- Loss: locked, three consecutive wrong words -> three err pulses, err_cnt+3, locked=0 after third; restart stream -> relock with err_cnt retained.
- Zero escape and SYNC reseed: in SEED send 00 -> expected=01; in SYNC send mismatching 55 -> expected=nxt(55)=8'hAA, match_cnt restarts, err stays 0.
- Saturation: CNT_W=4, LOSS_CNT=20, 17 consecutive misses while locked -> err_cnt stops at 4'hF, seg=decode(F).
- Reset mid-run: rst asserted with valid=1 while locked -> next cycle locked=0, err=0, err_cnt=0, seg=8'h03; valid gaps inside a locked stream -> no state change.
